uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver: recovers 8N1 frames from the asynchronous `rx_in` line and presents each byte on a valid/ready handshake. It is the receiving end of the link driven by our UART transmitter. It derives mid-bit sample timing from its own internal counter rather than an external pulse source, so it runs from one system clock. It sits between the board RX pin and the byte-consuming logic.

## Interface
- `CLKS_PER_BIT`, 868: system clocks per bit; 868 = 100 MHz / 115200. Must be ≥ 4.
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_in`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  DATA_BITS  last good byte; reset 0.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte; reset 0.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0; reset 0.
- `overrun`  out  1  one-cycle pulse when a byte overwrites an unconsumed byte; reset 0.

## Operation
- `rx_in` passes through a 2-flop synchronizer; the synchronizer flops reset to 1. Call the result `rx_s`.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide and counts 0..CLKS_PER_BIT-1. It clears on every state change. Define H = CLKS_PER_BIT/2, integer divide.
- IDLE: on `rx_s==0`, go to START.
- START: when `cnt==H-1`, sample `rx_s`. If it is 0, go to DATA with bit index 0. If it is 1, treat it as a glitch and return to IDLE.
- DATA: when `cnt==CLKS_PER_BIT-1`, shift `rx_s` into the shift register at the MSB, shifting right so the data ends up LSB first. After DATA_BITS samples, go to STOP.
- STOP: when `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
  - If it is 1: load `rx_data` from the shift register, set `rx_valid`, and go to IDLE. The stop bit is sampled mid-bit, so the next start edge is still caught.
  - If it is 0: pulse `frame_err`, leave `rx_data` and `rx_valid` unchanged, and go to BREAK.
- BREAK: wait for `rx_s==1`, then go to IDLE. A line held low therefore produces exactly one `frame_err`.
- Handshake: `rx_valid` clears on the cycle after `rx_valid & rx_ready`. `rx_data` is stable while `rx_valid` is 1, except when a new byte overwrites it.
- A byte completes while `rx_valid==1` and `rx_ready==0`:
  - `rx_data` takes the new byte.
  - `rx_valid` stays 1.
  - `overrun` pulses for one cycle.
- A byte completes in the same cycle as `rx_valid & rx_ready`: the new byte is loaded, `rx_valid` stays 1, and there is no `overrun`.
- `rst` at any point, including mid-frame:
  - All outputs return to their reset values.
  - The state returns to IDLE.
  - The shift register clears.
  - The synchronizer reloads 1.

## Timing
- Input latency is 2 cycles through the synchronizer. Let T0 be the cycle in which IDLE first sees `rx_s==0`; the state is START from T0+1.
- Start bit is checked at T0+H. Data bit i is sampled at T0+H+(i+1)·CLKS_PER_BIT. The stop bit is sampled at T0+H+(DATA_BITS+1)·CLKS_PER_BIT.
- `rx_valid` or `frame_err` is asserted on the cycle after the stop sample.
- With the defaults, `rx_valid` rises at T0+8247.
- The sampling error budget is one clock of quantization plus two cycles of synchronizer skew. This is acceptable for a ±2 % baud mismatch at CLKS_PER_BIT ≥ 16.
- There is no combinational path from input to output.

## Structure
- Shared package `uart_pkg`:
  - state enum: IDLE, START, DATA, STOP, BREAK;
  - `CLKS_PER_BIT_115200 = 868`;
  - `DATA_BITS_DEFAULT = 8`.
  - The UART transmitter uses the same package.
- One sub-module, `sync_2ff`: a 1-bit two-flop synchronizer with a parameterized reset value, reused for other asynchronous pins.

## Test plan
All scenarios use CLKS_PER_BIT=16, so H=8.
- **Good byte.** Drive an 8N1 frame of 0xA5 with `rx_ready=1` → `rx_data=0xA5` and `rx_valid` high at T0+153 for 1 cycle; `frame_err=0`.
- **Glitch.** Pulse `rx_in` low for 4 cycles, then hold it high → no `rx_valid`, no `frame_err`, FSM back in IDLE by T0+9.
- **Framing error.** Send a frame of 0x3C with stop bit 0 → `frame_err` pulses once at T0+153; `rx_valid` stays 0; `rx_data` unchanged; FSM stays in BREAK until the line goes high.
- **Overrun.** Send 0x11 then 0x22 back-to-back with `rx_ready=0` → `rx_data=0x22`, `overrun` pulses once, `rx_valid` stays 1. Then raise `rx_ready` for 1 cycle → `rx_valid` is 0 on the next cycle.
- **Reset mid-frame.** Assert `rst` during data bit 3 of a frame of 0xFF → all outputs 0 on the next cycle. A following clean frame of 0x5A is received with `rx_data=0x5A`.
- **Break.** Hold `rx_in` low for 40 bit times → exactly one `frame_err` and no `rx_valid`. Then release the line and send 0x81 → 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default link constants.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

   // 100 MHz system clock divided down to 115200 baud
   localparam int CLKS_PER_BIT_115200 = 868;
   localparam int DATA_BITS_DEFAULT   = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_t;

   // Counter value of the last cycle before the middle of a bit
   function automatic int half_bit_last(input int clks_per_bit);
      return (clks_per_bit / 2) - 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous pins, with a selectable reset level.
// Latency: 2 clk cycles from pin to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; both reload the reset level so the line looks idle after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples rx_in with an internal bit counter and presents each byte on valid/ready.
// Latency: byte visible 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the start edge reaches rx_in.
// Backpressure: none toward the line; an unconsumed byte is overwritten by the next one and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
   parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS + 1);

   // Last count of a full bit period, and last count before mid-bit of the start bit
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit_last(CLKS_PER_BIT));
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_t          state;
   uart_state_t          state_next;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;

   // Strobes from the FSM to the datapath
   logic                 shift_en;
   logic                 load_byte;
   logic                 stop_bad;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_in),
      .q   (rx_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and sample strobes; sampling points are fixed counter values within each state
   always_comb begin
      state_next = state;
      shift_en   = 1'b0;
      load_byte  = 1'b0;
      stop_bad   = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
            end
         end
         START: begin
            // A start bit that is high again by mid-bit was a glitch
            if (cnt == CNT_HALF) begin
               state_next = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               shift_en = 1'b1;
               if (bit_idx == IDX_LAST) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            // Leaving at mid stop bit keeps the next start edge in reach
            if (cnt == CNT_LAST) begin
               if (rx_s) begin
                  load_byte  = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_bad   = 1'b1;
                  state_next = BREAK;
               end
            end
         end
         BREAK: begin
            // Hold here while the line stays low so a break yields a single frame_err
            if (rx_s) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Bit-period counter: restarts on every state change and wraps once per bit
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (state_next != state) begin
         cnt <= '0;
      end else if (state == IDLE || state == BREAK) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Data bit index: counts samples taken while in DATA, zero everywhere else
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_idx <= '0;
      end else if (state_next != DATA) begin
         bit_idx <= '0;
      end else if (shift_en) begin
         bit_idx <= bit_idx + 1'b1;
      end
   end

   // Shift register: new bits enter at the MSB so the first (LSB) bit lands in bit 0
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
      end else if (shift_en) begin
         shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
   end

   // Output register and handshake; a load wins over a same-cycle accept so the new byte is not lost
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= load_byte & rx_valid & ~rx_ready;
         if (load_byte) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid & rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// Latency: expects a byte or frame_err 155 cycles after the start bit is first driven.
// Backpressure: rx_ready driven directly, fixed or randomized.
`timescale 1ns/1ps
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB = 16;
   // 2 synchronizer cycles + half bit + 9 full bits + 1 register cycle
   localparam int FRAME_DONE = 2 + CPB / 2 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   always #5 clk = ~clk;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   typedef struct {
      int         at;
      logic       good;
      logic [7:0] data;
   } ev_t;

   typedef struct {
      logic [7:0] bval;
      logic       stop;
      logic       ready;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_ferr;
      logic       exp_valid_next;
   } vec_t;

   int         n_vec = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   ev_t        ev_q[$];
   logic       m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;
   logic       m_ferr  = 1'b0;
   logic       m_ovr   = 1'b0;
   bit         rdy_rand = 1'b0;
   int         ferr_cnt = 0;
   int         ovr_cnt  = 0;
   int         vrise_cnt = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] snap_data;
   logic       snap_valid;
   logic       snap_ferr;
   logic       snap_valid_next;
   vec_t       vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   // One clock: advance the reference model by one edge, then compare all outputs
   task automatic step();
      logic hs;
      ev_t  e;
      @(posedge clk);
      #1;
      cyc++;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (rst) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         ev_q.delete();
      end else begin
         hs = m_valid & rx_ready;
         if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
            e = ev_q.pop_front();
            if (e.good) begin
               m_ovr   = m_valid & ~rx_ready;
               m_valid = 1'b1;
               m_data  = e.data;
            end else begin
               m_ferr = 1'b1;
               if (hs) m_valid = 1'b0;
            end
         end else if (hs) begin
            m_valid = 1'b0;
         end
      end
      chk("outputs{valid,data,ferr,ovr}", 32'({rx_valid, rx_data, frame_err, overrun}),
          32'({m_valid, m_data, m_ferr, m_ovr}));
      ferr_cnt += int'(frame_err);
      ovr_cnt  += int'(overrun);
      if (rx_valid && !prev_valid) vrise_cnt++;
      prev_valid = rx_valid;
      if (rdy_rand) rx_ready = ($urandom_range(0, 2) == 0);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) step();
   endtask

   // Drive one 8N1 frame; the expected completion is queued for the model
   task automatic send_frame(input logic [7:0] bval, input logic stop);
      int k;
      k = cyc;
      ev_q.push_back('{k + FRAME_DONE, stop, bval});
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < CPB; c++) begin
            if (b == 0)      rx_in = 1'b0;
            else if (b == 9) rx_in = stop;
            else             rx_in = bval[b-1];
            step();
            if (cyc == k + FRAME_DONE) begin
               snap_data  = rx_data;
               snap_valid = rx_valid;
               snap_ferr  = frame_err;
            end
            if (cyc == k + FRAME_DONE + 1) snap_valid_next = rx_valid;
         end
      end
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      idle(4);
      rx_ready = 1'b0;
   endtask

   initial begin
      int         k;
      logic [7:0] rb;
      logic       rg;

      rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b0;
      step();
      step();
      chk("reset_valid", 32'(rx_valid), 32'd0);
      chk("reset_data", 32'(rx_data), 32'd0);
      chk("reset_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b0;
      idle(20);

      // Directed frames: {byte, stop, ready, exp data, exp valid, exp ferr, exp valid next cycle}
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         rx_ready = vecs[i].ready;
         send_frame(vecs[i].bval, vecs[i].stop);
         chk("tbl_data", 32'(snap_data), 32'(vecs[i].exp_data));
         chk("tbl_valid", 32'(snap_valid), 32'(vecs[i].exp_valid));
         chk("tbl_ferr", 32'(snap_ferr), 32'(vecs[i].exp_ferr));
         chk("tbl_valid_next", 32'(snap_valid_next), 32'(vecs[i].exp_valid_next));
         idle(20);
         drain();
      end

      // Glitch: 4 low cycles, start bit rejected at mid-bit
      ferr_cnt = 0; vrise_cnt = 0;
      k = cyc;
      rx_in = 1'b0;
      repeat (4) step();
      rx_in = 1'b1;
      repeat (6) step();
      chk("glitch_start_state", 32'(dut.state), 32'(START));
      step();
      chk("glitch_idle_state", 32'(dut.state), 32'(IDLE));
      idle(200);
      chk("glitch_ferr_cnt", 32'(ferr_cnt), 32'd0);
      chk("glitch_valid_cnt", 32'(vrise_cnt), 32'd0);

      // Framing error with line left low: stays in BREAK until it rises
      send_frame(8'h3C, 1'b0);
      repeat (20) step();
      chk("ferr_break_state", 32'(dut.state), 32'(BREAK));
      rx_in = 1'b1;
      step();
      step();
      chk("ferr_break_hold", 32'(dut.state), 32'(BREAK));
      step();
      chk("ferr_break_exit", 32'(dut.state), 32'(IDLE));
      idle(20);

      // Overrun: two back-to-back bytes without consuming
      ovr_cnt = 0;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(10);
      chk("ovr_data", 32'(rx_data), 32'h22);
      chk("ovr_valid", 32'(rx_valid), 32'd1);
      chk("ovr_cnt", 32'(ovr_cnt), 32'd1);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      chk("ovr_accept", 32'(rx_valid), 32'd0);
      idle(10);

      // Reset during data bit 3 of 0xFF with a byte still pending
      send_frame(8'h3C, 1'b1);
      idle(10);
      k = cyc;
      rx_in = 1'b0;
      repeat (CPB) step();
      rx_in = 1'b1;
      while (cyc < k + 4 * CPB + CPB / 2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstmid_valid", 32'(rx_valid), 32'd0);
      chk("rstmid_data", 32'(rx_data), 32'd0);
      chk("rstmid_state", 32'(dut.state), 32'(IDLE));
      idle(120);
      send_frame(8'h5A, 1'b1);
      chk("rstmid_next_data", 32'(snap_data), 32'h5A);
      chk("rstmid_next_valid", 32'(snap_valid), 32'd1);
      idle(10);
      drain();

      // Break: 40 bit times low, then a clean 0x81
      ferr_cnt = 0; vrise_cnt = 0;
      k = cyc;
      ev_q.push_back('{k + FRAME_DONE, 1'b0, 8'h00});
      rx_in = 1'b0;
      repeat (40 * CPB) step();
      chk("break_ferr_cnt", 32'(ferr_cnt), 32'd1);
      chk("break_valid_cnt", 32'(vrise_cnt), 32'd0);
      idle(20);
      send_frame(8'h81, 1'b1);
      chk("break_next_data", 32'(snap_data), 32'h81);
      chk("break_next_valid", 32'(snap_valid), 32'd1);
      idle(10);
      drain();

      // Random frames, random stop bits and gaps, randomized consumer
      rdy_rand = 1'b1;
      for (int i = 0; i < 25; i++) begin
         rb = 8'($urandom_range(0, 255));
         rg = ($urandom_range(0, 3) != 0);
         send_frame(rb, rg);
         idle(rg ? int'($urandom_range(0, 20)) : int'($urandom_range(1, 20)));
      end
      rdy_rand = 1'b0;
      rx_ready = 1'b1;
      idle(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

endmodule
